serial_mag_cmp: RTL



---
 rtl/serial_mag_cmp_if.sv | 28 ++
 rtl/serial_mag_cmp.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_mag_cmp_if.sv
// Handshake bundle for the serial magnitude comparator: digit-pair stream in,
// single greater/less/equal result out.
interface serial_mag_cmp_if;
    // Both channels are valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; the producer holds its payload
    // stable while valid is high and ready is low.
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       res_valid;
    logic       res_ready;
    logic       agb;
    logic       alb;
    logic       aeqb;
    logic       busy;

    modport master (
        output start, in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, agb, alb, aeqb, busy
    );

    modport slave (
        input  start, in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, agb, alb, aeqb, busy
    );
endinterface

// File: rtl/serial_mag_cmp.sv
// Sequential magnitude comparator: folds MSB-first 2-bit digit compares over
// DIGITS accepted digit pairs and presents one registered GT/LT/EQ result.
module serial_mag_cmp #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_mag_cmp_if.slave  bus,
    output logic [1:0]       state_o
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    state_t        state_q;
    rel_t          rel_q;
    rel_t          rel_d;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q;
    logic          res_valid_q;
    logic          agb_q;
    logic          alb_q;
    logic          aeqb_q;
    logic          busy_q;

    // The first unequal digit decides; later digits cannot override it.
    always_comb begin
        rel_d = rel_q;
        if (rel_q == REL_EQ) begin
            if (bus.in_a > bus.in_b) begin
                rel_d = REL_GT;
            end else if (bus.in_a < bus.in_b) begin
                rel_d = REL_LT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rel_q       <= REL_EQ;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            agb_q       <= 1'b0;
            alb_q       <= 1'b0;
            aeqb_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= RUN;
                        rel_q      <= REL_EQ;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    // Every digit is consumed even after the decision, keeping stream framing.
                    if (bus.in_valid && in_ready_q) begin
                        rel_q <= rel_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            agb_q       <= (rel_d == REL_GT);
                            alb_q       <= (rel_d == REL_LT);
                            aeqb_q      <= (rel_d == REL_EQ);
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        agb_q       <= 1'b0;
                        alb_q       <= 1'b0;
                        aeqb_q      <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    agb_q       <= 1'b0;
                    alb_q       <= 1'b0;
                    aeqb_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.agb       = agb_q;
    assign bus.alb       = alb_q;
    assign bus.aeqb      = aeqb_q;
    assign bus.busy      = busy_q;
    assign state_o       = state_q;
endmodule
